mac_alu: RTL and testbench



---
 rtl/mac_alu_if.sv | 14 +
 rtl/mac_alu.sv | 65 ++++++
 tb/tb_mac_alu.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mac_alu_if.sv
// Operand/result bundle for mac_alu: the master drives operands and the valid strobe,
// and the slave returns the accumulator value.
interface mac_alu_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 39
);
  logic [IN_W-1:0]  X;
  logic [IN_W-1:0]  B;
  logic             valid_in;
  logic [ACC_W-1:0] y;

  modport master (output X, output B, output valid_in, input y);
  modport slave  (input X, input B, input valid_in, output y);
endinterface

// File: rtl/mac_alu.sv
// Unsigned multiply-accumulate: acc += X*B on each valid edge; y is the accumulator register.
// Define MAC_ALU_SAT_EN to clamp to all ones on overflow instead of wrapping modulo 2^ACC_W.
module mac_alu #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 39
) (
  input  logic      clk,
  input  logic      R,
  mac_alu_if.slave  bus
);
  localparam int PROD_W = 2 * IN_W;

  logic [PROD_W-1:0] pp [IN_W];
  logic [PROD_W-1:0] product;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  acc_next;

  // One shifted copy of X per multiplier bit, gated by that bit.
  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_pp
      assign pp[gi] = bus.B[gi] ? ({{IN_W{1'b0}}, bus.X} << gi) : '0;
    end
  endgenerate

  always_comb begin
    product = '0;
    for (int i = 0; i < IN_W; i++) begin
      product = product + pp[i];
    end
  end

  // One extra bit on top of the accumulator exposes the carry out of the add.
  assign sum_ext = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

`ifdef MAC_ALU_SAT_EN
  always_comb begin
    acc_next = acc_reg;
    if (bus.valid_in) begin
      acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end
  end
`else
  logic unused_carry;
  assign unused_carry = sum_ext[ACC_W];

  always_comb begin
    acc_next = acc_reg;
    if (bus.valid_in) begin
      acc_next = sum_ext[ACC_W-1:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (R) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign bus.y = acc_reg;
endmodule

// File: tb/tb_mac_alu.sv
// Scoreboard bench for mac_alu: the driver pushes reference-model results, and a monitor
// compares them with y one cycle later. Directed test-plan steps are followed by random traffic.
module tb_mac_alu;
  localparam int IN_W  = 16;
  localparam int ACC_W = 39;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  typedef struct {
    longint unsigned exp;
    string           name;
  } item_t;

  logic clk = 1'b0;
  logic R   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  item_t exp_q[$];
  longint unsigned model_acc = 0;

  mac_alu_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  mac_alu #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: the spec's rules in plain 64-bit arithmetic.
  function automatic longint unsigned ref_next(longint unsigned acc, bit r, bit v,
                                               int unsigned x, int unsigned b);
    longint unsigned s;
    if (r) return 64'd0;
    if (!v) return acc;
    s = acc + (64'(x) * 64'(b));
`ifdef MAC_ALU_SAT_EN
    return (s > ACC_MAX) ? ACC_MAX : s;
`else
    return s % (ACC_MAX + 64'd1);
`endif
  endfunction

  // lit >= 0 supplies a hand-computed expectation instead of the model's value.
  task automatic drive(input bit r, input bit v, input int unsigned x, input int unsigned b,
                       input string name, input longint lit = -1);
    item_t it;
    @(negedge clk);
    R            = r;
    bus.valid_in = v;
    bus.X        = x[IN_W-1:0];
    bus.B        = b[IN_W-1:0];
    model_acc    = ref_next(model_acc, r, v, x, b);
    it.exp       = (lit >= 0) ? longint'(unsigned'(lit)) : model_acc;
    it.name      = name;
    exp_q.push_back(it);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      item_t it;
      logic [ACC_W-1:0] e;
      it = exp_q.pop_front();
      e  = it.exp[ACC_W-1:0];
      checks++;
      txn++;
      if (bus.y !== e) begin
        errors++;
        $display("FAIL %s: y=%0d expected=%0d", it.name, bus.y, e);
      end else begin
        $display("txn %0d %s y=%0d", txn, it.name, bus.y);
      end
    end
  end

  initial begin
    bus.X        = '0;
    bus.B        = '0;
    bus.valid_in = 1'b0;

    drive(1, 1, 0, 0, "reset", 0);
    drive(0, 1, 2, 3, "acc_2x3", 6);
    drive(0, 1, 5, 4, "acc_5x4", 26);
    drive(0, 1, 1, 1, "acc_1x1", 27);
    drive(0, 1, 16, 3, "acc_16x3", 75);
    for (int i = 0; i < 3; i++) drive(0, 0, 16'hFFFF, 16'hFFFF, "hold", 75);
    drive(1, 1, 7, 9, "reset_priority", 0);
    drive(0, 1, 7, 9, "after_reset", 63);
    drive(0, 1, 0, 16'h1234, "zero_x", 63);
    drive(0, 1, 16'h0555, 0, "zero_b", 63);

    drive(1, 0, 0, 0, "reset_before_wrap", 0);
    drive(0, 1, 16'hFFFF, 16'hFFFF, "max_single", 64'd4294836225);
    for (int i = 1; i < 127; i++) drive(0, 1, 16'hFFFF, 16'hFFFF, "max_run");
    drive(0, 1, 16'hFFFF, 16'hFFFF, "max_128", 64'd549739036800);
`ifdef MAC_ALU_SAT_EN
    drive(0, 1, 16'hFFFF, 16'hFFFF, "saturate", 64'd549755813887);
    drive(0, 1, 16'hFFFF, 16'hFFFF, "sat_stays", 64'd549755813887);
    drive(0, 1, 1, 1, "sat_small", 64'd549755813887);
    drive(0, 0, 1, 1, "sat_hold", 64'd549755813887);
`else
    drive(0, 1, 16'hFFFF, 16'hFFFF, "wrap", 64'd4278059137);
    drive(0, 1, 1, 1, "after_wrap", 64'd4278059138);
    drive(0, 0, 1, 1, "wrap_hold", 64'd4278059138);
`endif
    drive(1, 1, 16'hFFFF, 16'hFFFF, "reset_after_overflow", 0);

    for (int i = 0; i < 400; i++) begin
      bit          r;
      bit          v;
      int unsigned x;
      int unsigned b;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      x = ($urandom_range(0, 3) == 0) ? 32'hFFFF : $urandom_range(0, 16'hFFFF);
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF : $urandom_range(0, 16'hFFFF);
      if ($urandom_range(0, 15) == 0) x = 0;
      drive(r, v, x, b, "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
